// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - control/status bundle between the reset sequencer and its environment
//
// Purpose: groups the software request, the upstream lock and the reset/status
// outputs of reset_sequencer so they travel as one port.
//
// Signals:
//   req       - software reset request, level-sensitive, synchronous to clk
//   lock      - upstream ready (e.g. PLL locked), already synchronous to clk
//   rst_out   - per-domain active-high resets, released in index order
//   done      - high when every rst_out bit is low
//   state     - current sequencer state code (0 ASSERT, 1 WAIT_LOCK, 2 RELEASE, 3 RUN)
//   lock_lost - sticky lock-loss-in-RUN flag, present only when
//               RESET_SEQUENCER_LOCK_MONITOR_EN is defined
//
// Modports: master drives req/lock (environment side), slave drives the
// resets and status (sequencer side).

interface reset_sequencer_if #(
    parameter int STAGES = 3
);
    logic              req;
    logic              lock;
    logic [STAGES-1:0] rst_out;
    logic              done;
    logic [1:0]        state;
`ifdef RESET_SEQUENCER_LOCK_MONITOR_EN
    logic              lock_lost;
`endif

    modport master (
        output req,
        output lock,
`ifdef RESET_SEQUENCER_LOCK_MONITOR_EN
        input  lock_lost,
`endif
        input  rst_out,
        input  done,
        input  state
    );

    modport slave (
        input  req,
        input  lock,
`ifdef RESET_SEQUENCER_LOCK_MONITOR_EN
        output lock_lost,
`endif
        output rst_out,
        output done,
        output state
    );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered release of synchronous reset domains after lock
//
// Purpose: holds every downstream reset domain in reset for at least
// MIN_ASSERT cycles, waits for the upstream lock, then releases rst_out[0],
// rst_out[1], ... one every DELAY cycles. A software request (req) or a loss
// of lock during release re-runs the whole sequence.
//
// Optional feature (macro RESET_SEQUENCER_LOCK_MONITOR_EN): lock loss while
// in RUN also re-runs the sequence and sets the sticky bus.lock_lost flag,
// which reset or req clears. Without the macro lock is ignored in RUN.
//
// Ports:
//   clk   - clock, all logic on the rising edge
//   reset - synchronous active-high block reset, highest priority
//   bus   - reset_sequencer_if.slave: req, lock in; rst_out, done, state
//           (and lock_lost with the monitor) out, all outputs registered
//
// Parameters:
//   STAGES     - number of reset outputs (>= 1)
//   MIN_ASSERT - cycles spent in ASSERT before lock is examined (>= 1)
//   DELAY      - cycles from RELEASE entry to the first release and between
//                consecutive releases (>= 1)

module reset_sequencer #(
    parameter int STAGES     = 3,
    parameter int MIN_ASSERT = 8,
    parameter int DELAY      = 16
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_ASSERT    = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    // One counter serves both the ASSERT hold and the RELEASE spacing, so it
    // is sized for the larger of the two terminal counts.
    localparam int MAX_CNT = (MIN_ASSERT > DELAY) ? MIN_ASSERT : DELAY;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int IDX_W   = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [CNT_W-1:0] MIN_TC   = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] DLY_TC   = CNT_W'(DELAY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [STAGES-1:0] r_rst_out;
    logic              r_done;
    logic              r_lock_lost;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [STAGES-1:0] w_rst_nxt;
    logic              w_done_nxt;
    logic              w_lock_lost_nxt;
    logic              w_restart;

    // State and datapath registers; every output is taken straight from here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_ASSERT;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_out   <= '1;
            r_done      <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_rst_out   <= w_rst_nxt;
            r_done      <= w_done_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_rst_nxt       = r_rst_out;
        w_lock_lost_nxt = r_lock_lost;
        w_restart       = 1'b0;

        if (bus.req) begin
            // req outranks any terminal count in the same cycle, and holding
            // it keeps the counter pinned at zero.
            w_restart       = 1'b1;
            w_lock_lost_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ASSERT: begin
                    w_rst_nxt = '1;
                    if (r_cnt == MIN_TC) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    w_rst_nxt = '1;
                    w_cnt_nxt = '0;
                    if (bus.lock) begin
                        w_state_nxt = S_RELEASE;
                        w_idx_nxt   = '0;
                    end
                end

                S_RELEASE: begin
                    if (!bus.lock) begin
                        w_restart = 1'b1;
                    end else if (r_cnt == DLY_TC) begin
                        // Release the current domain; the final release moves
                        // to RUN in the same cycle so done rises with it.
                        w_rst_nxt[r_idx] = 1'b0;
                        w_cnt_nxt        = '0;
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt = S_RUN;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    w_rst_nxt = '0;
`ifdef RESET_SEQUENCER_LOCK_MONITOR_EN
                    if (!bus.lock) begin
                        w_restart       = 1'b1;
                        w_lock_lost_nxt = 1'b1;
                    end
`endif
                end

                default: begin
                    w_restart = 1'b1;
                end
            endcase
        end

        if (w_restart) begin
            w_state_nxt = S_ASSERT;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_rst_nxt   = '1;
        end

        w_done_nxt = (w_rst_nxt == '0);
    end

    assign bus.rst_out = r_rst_out;
    assign bus.done    = r_done;
    assign bus.state   = r_state;
`ifdef RESET_SEQUENCER_LOCK_MONITOR_EN
    assign bus.lock_lost = r_lock_lost;
`else
    // Lock-lost tracking only matters with the monitor compiled in.
    logic w_unused_lock_lost;
    assign w_unused_lock_lost = r_lock_lost;
`endif

endmodule
